multicycle_datapath: RTL and testbench

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/datapath_pkg.sv | 42 ++++
 rtl/regfile_p.sv | 42 ++++
 rtl/multicycle_datapath.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types and constants for the multicycle datapath.
//   alu_op_e    : 3-bit ALU operation codes
//   state_e     : sequencer states
//   ctrl_t      : decode controls latched on instruction handshake
//   reg_in_range: true when a 5-bit register index exists in the file
package datapath_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;
    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned REG_IDX_W    = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MEM_REQ,
        MEM_WAIT,
        WB
    } state_e;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [2:0] alu_control;
    } ctrl_t;

    function automatic logic reg_in_range(input logic [REG_IDX_W-1:0] idx,
                                          input int unsigned nregs);
        return 32'(idx) < nregs;
    endfunction

endpackage

// File: rtl/regfile_p.sv
// Register file: NREGS x XLEN, two async read ports plus a debug read port,
// one synchronous write port, async active-low clear of every entry.
//   clk, rst          : clock, async active-low reset
//   ra1/rd1, ra2/rd2  : operand read ports
//   dbg_addr/dbg_data : observation read port
//   we, wa, wd        : write port; writes to entry 0 are dropped
module regfile_p #(
    parameter  int unsigned XLEN  = 64,
    parameter  int unsigned NREGS = 32,
    localparam int unsigned AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [NREGS];

    // Storage; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1      = (ra1 == '0)      ? '0 : regs[ra1];
    assign rd2      = (ra2 == '0)      ? '0 : regs[ra2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle integer datapath: accepts one decoded instruction at a time,
// executes it through EXEC, optional MEM_REQ/MEM_WAIT, and WB, then retires.
//   clk, rst                    : clock, async active-low reset
//   instr_valid/ready, instruction, imm_ext, alu_control, reg_write,
//   alu_src, mem_read, mem_write, mem_to_reg : instruction + decode controls
//   mem_req_valid/ready, mem_we, mem_addr, mem_wdata : memory request
//   mem_rsp_valid, mem_rdata    : load response
//   retire, rd_addr, zero, alu_result, debug_out : status
module multicycle_datapath
    import datapath_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEFAULT,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned DEBUG_REG = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [INSTR_W-1:0]   instruction,
    input  logic [XLEN-1:0]      imm_ext,
    input  logic [2:0]           alu_control,
    input  logic                 reg_write,
    input  logic                 alu_src,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 mem_to_reg,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 retire,
    output logic [REG_IDX_W-1:0] rd_addr,
    output logic                 zero,
    output logic [XLEN-1:0]      alu_result,
    output logic [XLEN-1:0]      debug_out
);

    localparam int unsigned AW       = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic        DBG_OK   = (DEBUG_REG < NREGS);
    localparam logic [AW-1:0] DBG_ADDR = AW'(DEBUG_REG);

    state_e state, next_state;
    ctrl_t  ctrl_q;

    logic [XLEN-1:0] imm_q, rs1_q, rs2_q, load_q;
    logic [XLEN-1:0] rf_rd1, rf_rd2, rf_dbg, rs1_val, rs2_val;
    logic [XLEN-1:0] alu_b, alu_y, wb_data;
    logic [REG_IDX_W-1:0] rs1_idx, rs2_idx, rd_idx;
    logic rf_we, instr_hs, req_hs;
    logic instr_ready_d, mem_req_valid_d, mem_we_d, retire_d;
    logic unused_instr_bits;

    assign rs1_idx  = instruction[19:15];
    assign rs2_idx  = instruction[24:20];
    assign rd_idx   = instruction[11:7];
    assign unused_instr_bits = ^{instruction[31:25], instruction[14:12], instruction[6:0]};

    assign instr_hs = instr_valid && instr_ready;
    assign req_hs   = mem_req_valid && mem_req_ready;

    // Indices beyond the populated file read as zero.
    assign rs1_val = reg_in_range(rs1_idx, NREGS) ? rf_rd1 : '0;
    assign rs2_val = reg_in_range(rs2_idx, NREGS) ? rf_rd2 : '0;

    assign wb_data = ctrl_q.mem_to_reg ? load_q : alu_result;
    assign rf_we   = (state == WB) && ctrl_q.reg_write && reg_in_range(rd_addr, NREGS);

    regfile_p #(
        .XLEN (XLEN),
        .NREGS(NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra1     (AW'(rs1_idx)),
        .ra2     (AW'(rs2_idx)),
        .rd1     (rf_rd1),
        .rd2     (rf_rd2),
        .dbg_addr(DBG_ADDR),
        .dbg_data(rf_dbg),
        .we      (rf_we),
        .wa      (AW'(rd_addr)),
        .wd      (wb_data)
    );

    assign debug_out = DBG_OK ? rf_dbg : '0;
    assign mem_addr  = alu_result;
    assign mem_wdata = rs2_q;

    // ALU on latched operands.
    always_comb begin
        alu_b = ctrl_q.alu_src ? imm_q : rs2_q;
        alu_y = '0;
        case (ctrl_q.alu_control)
            3'(ALU_ADD): alu_y = rs1_q + alu_b;
            3'(ALU_SUB): alu_y = rs1_q - alu_b;
            3'(ALU_AND): alu_y = rs1_q & alu_b;
            3'(ALU_OR):  alu_y = rs1_q | alu_b;
            3'(ALU_SLT): alu_y = XLEN'($signed(rs1_q) < $signed(alu_b));
            default:     alu_y = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a store wins when both read and write are latched.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (instr_hs) next_state = EXEC;
            EXEC:     next_state = (ctrl_q.mem_read || ctrl_q.mem_write) ? MEM_REQ : WB;
            MEM_REQ:  if (req_hs) next_state = ctrl_q.mem_write ? WB : MEM_WAIT;
            MEM_WAIT: if (mem_rsp_valid) next_state = WB;
            WB:       next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Moore outputs, decoded from the upcoming state so they register cleanly.
    always_comb begin
        instr_ready_d   = 1'b0;
        mem_req_valid_d = 1'b0;
        mem_we_d        = 1'b0;
        retire_d        = 1'b0;
        case (next_state)
            IDLE:    instr_ready_d = 1'b1;
            MEM_REQ: begin
                mem_req_valid_d = 1'b1;
                mem_we_d        = ctrl_q.mem_write;
            end
            WB:      retire_d = 1'b1;
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_ready   <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            retire        <= 1'b0;
        end else begin
            instr_ready   <= instr_ready_d;
            mem_req_valid <= mem_req_valid_d;
            mem_we        <= mem_we_d;
            retire        <= retire_d;
        end
    end

    // Datapath registers: operand capture, ALU result, load data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            load_q     <= '0;
            rd_addr    <= '0;
            alu_result <= '0;
            zero       <= 1'b1;
        end else begin
            if (instr_hs) begin
                ctrl_q <= '{reg_write:   reg_write,
                            alu_src:     alu_src,
                            mem_read:    mem_read,
                            mem_write:   mem_write,
                            mem_to_reg:  mem_to_reg,
                            alu_control: alu_control};
                imm_q   <= imm_ext;
                rs1_q   <= rs1_val;
                rs2_q   <= rs2_val;
                rd_addr <= rd_idx;
            end
            if (state == EXEC) begin
                alu_result <= alu_y;
                zero       <= (alu_y == '0);
            end
            if ((state == MEM_WAIT) && mem_rsp_valid) begin
                load_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Randomized self-checking bench for multicycle_datapath against an
// instruction-level reference model (register array + arithmetic rules).
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, instr_ready;
    logic [31:0] instruction;
    logic [63:0] imm_ext;
    logic [2:0]  alu_control;
    logic        reg_write, alu_src, mem_read, mem_write, mem_to_reg;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;
    logic        retire, zero;
    logic [4:0]  rd_addr;
    logic [63:0] alu_result, debug_out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] mreg [32];

    multicycle_datapath #(.XLEN(64), .NREGS(32), .DEBUG_REG(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instruction  (instruction),
        .imm_ext      (imm_ext),
        .alu_control  (alu_control),
        .reg_write    (reg_write),
        .alu_src      (alu_src),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata    (mem_rdata),
        .retire       (retire),
        .rd_addr      (rd_addr),
        .zero         (zero),
        .alu_result   (alu_result),
        .debug_out    (debug_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] alu_ref(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    task automatic wait_ready;
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            tick;
            n++;
        end
        check("instr_ready", 64'(instr_ready), 64'd1);
    endtask

    // Issue one instruction, act as memory, check timing and results, update model.
    task automatic run(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                       input logic [63:0] imm, input logic asrc, input logic rw,
                       input logic mr, input logic mw, input logic m2r,
                       input int stall, input int wait_n, input logic [63:0] rdata);
        logic [63:0] a, b, y;
        bit is_st, is_ld, req_done;
        int exp_lat, c, stall_cnt, wcnt, req_cycles;
        a = mreg[rs1];
        b = asrc ? imm : mreg[rs2];
        y = alu_ref(op, a, b);
        is_st = mw;
        is_ld = mr && !mw;
        exp_lat = is_st ? 3 + stall : (is_ld ? 4 + stall + wait_n : 2);
        stall_cnt = 0; wcnt = 0; req_cycles = 0; req_done = 0;

        wait_ready;
        instruction = {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
        imm_ext = imm; alu_control = op; reg_write = rw; alu_src = asrc;
        mem_read = mr; mem_write = mw; mem_to_reg = m2r;
        instr_valid = 1'b1;
        tick;
        instr_valid = 1'b0;
        // Scramble controls: they must only matter at the handshake.
        instruction = $urandom; imm_ext = {$urandom, $urandom}; alu_control = 3'($urandom);
        reg_write = 1'($urandom); alu_src = 1'($urandom); mem_read = 1'($urandom);
        mem_write = 1'($urandom); mem_to_reg = 1'($urandom);

        c = 1;
        while (!retire && c < 64) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (mem_req_valid) begin
                req_cycles++;
                check("mem_req_valid", 64'(mem_req_valid), 64'(is_st || is_ld));
                check("mem_addr", mem_addr, y);
                check("mem_wdata", mem_wdata, mreg[rs2]);
                check("mem_we", 64'(mem_we), 64'(is_st));
                if (stall_cnt < stall) stall_cnt++;
                else begin
                    mem_req_ready = 1'b1;
                    req_done = 1'b1;
                end
            end else if (req_done && is_ld) begin
                if (wcnt == wait_n) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata = rdata;
                end else begin
                    mem_rdata = {$urandom, $urandom};
                end
                wcnt++;
            end else begin
                mem_rsp_valid = 1'($urandom);
                mem_rdata = {$urandom, $urandom};
            end
            tick;
            c++;
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;

        check("latency", 64'(c), 64'(exp_lat));
        if (is_st || is_ld) check("req_cycles", 64'(req_cycles), 64'(stall + 1));
        check("alu_result", alu_result, y);
        check("zero", 64'(zero), 64'(y == 64'd0));
        check("rd_addr", 64'(rd_addr), 64'(rd));
        if (rw && rd != 0) mreg[rd] = m2r ? rdata : y;
        tick;
        check("ready_after_retire", 64'(instr_ready), 64'd1);
        check("retire_pulse", 64'(retire), 64'd0);
        check("debug_out", debug_out, mreg[10]);
    endtask

    initial begin
        logic [2:0]  op;
        logic [63:0] imm;
        logic        asrc;
        int          kind, rd, r1, r2;

        rst = 1'b0;
        instr_valid = 1'b0; instruction = '0; imm_ext = '0; alu_control = '0;
        reg_write = 1'b0; alu_src = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_to_reg = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        for (int k = 0; k < 32; k++) mreg[k] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_instr_ready", 64'(instr_ready), 64'd0);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_retire", 64'(retire), 64'd0);
        check("rst_alu_result", alu_result, 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_debug_out", debug_out, 64'd0);
        #3 rst = 1'b1;
        tick;
        check("ready_after_release", 64'(instr_ready), 64'd1);

        // x1=5, x2=7 via add-immediate from x0.
        run(3'd0, 1, 0, 0, 64'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
        run(3'd0, 2, 0, 0, 64'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
        // add x3,x1,x2 -> 12
        run(3'd0, 3, 1, 2, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
        // sub x4,x1,x1 -> 0, zero
        run(3'd1, 4, 1, 1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
        // write x0, then read it back through or
        run(3'd0, 0, 1, 2, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
        run(3'd3, 5, 0, 0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
        // slt signed and an undefined opcode
        run(3'd5, 6, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
        run(3'd6, 7, 1, 2, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
        // store x2 to x1+8 with 3 stall cycles
        run(3'd0, 0, 1, 2, 64'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 0, 64'd0);
        // load x10 from 13, response after 2 idle cycles
        run(3'd0, 10, 0, 0, 64'd13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 2, 64'hDEAD);
        // read and write both set behaves as store
        run(3'd0, 9, 1, 2, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 64'd0);

        // Reset while waiting on a load response.
        wait_ready;
        instruction = {7'd0, 5'd0, 5'd1, 3'd0, 5'd11, 7'h03};
        imm_ext = '0; alu_control = 3'd0; reg_write = 1'b1; alu_src = 1'b1;
        mem_read = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1;
        instr_valid = 1'b1;
        tick;
        instr_valid = 1'b0;
        tick;
        check("abort_req_valid", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        check("abort_in_wait", 64'(mem_req_valid), 64'd0);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 32; k++) mreg[k] = '0;
        check("abort_instr_ready", 64'(instr_ready), 64'd0);
        check("abort_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("abort_retire", 64'(retire), 64'd0);
        check("abort_alu_result", alu_result, 64'd0);
        check("abort_zero", 64'(zero), 64'd1);
        check("abort_debug_out", debug_out, 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata = 64'h1234;
        @(posedge clk);
        #4;
        mem_rsp_valid = 1'b0;
        rst = 1'b1;
        tick;
        check("abort_ready_release", 64'(instr_ready), 64'd1);
        check("abort_no_req", 64'(mem_req_valid), 64'd0);

        // Spurious response in IDLE.
        mem_rsp_valid = 1'b1;
        mem_rdata = 64'hBEEF;
        tick;
        tick;
        mem_rsp_valid = 1'b0;
        check("spurious_retire", 64'(retire), 64'd0);
        check("spurious_ready", 64'(instr_ready), 64'd1);
        run(3'd3, 7, 1, 10, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
        run(3'd3, 8, 11, 2, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);

        // Randomized mix of ALU, store and load instructions.
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            rd   = $urandom_range(0, 31);
            r1   = $urandom_range(0, 31);
            r2   = $urandom_range(0, 31);
            if (kind < 6) begin
                op   = 3'($urandom);
                imm  = {$urandom, $urandom};
                asrc = 1'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    op = 3'd1;
                    r2 = r1;
                    asrc = 1'b0;
                end
                run(op, rd, r1, r2, imm, asrc, 1'($urandom), 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
            end else if (kind < 8) begin
                run(3'd0, rd, r1, r2, 64'($urandom_range(0, 255)), 1'b1, 1'b0,
                    1'($urandom), 1'b1, 1'b0, $urandom_range(0, 3), 0, 64'd0);
            end else begin
                run(3'd0, rd, r1, 0, 64'($urandom_range(0, 255)), 1'b1, 1'b1,
                    1'b1, 1'b0, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3),
                    {$urandom, $urandom});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
